// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next PC from NEXT/BRANCH/JUMP/CALL/RETURN, with a circular return-address stack.
// Latency: PC, Depth and error flags update one Clock edge after Op is sampled; Empty/Full follow Depth combinationally.
// Backpressure: Stall=1 freezes PC, RAS and Depth (ClearErr still applies); PC_SEQ_PREV_EN adds the PrevPC capture register.
module pc_sequencer #(
   parameter int ADDR_W                    = 16,
   parameter int OFFSET_W                  = 8,
   parameter int STACK_DEPTH               = 4,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
   localparam int DEPTH_W                  = $clog2(STACK_DEPTH + 1)
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                Stall,
   input  logic [2:0]          Op,
   input  logic [OFFSET_W-1:0] Offset,
   input  logic [ADDR_W-1:0]   Target,
   input  logic                ClearErr,
   output logic [ADDR_W-1:0]   PC,
   output logic [DEPTH_W-1:0]  Depth,
   output logic                Empty,
   output logic                Full,
   output logic                Overflow,
`ifdef PC_SEQ_PREV_EN
   output logic                Underflow,
   output logic [ADDR_W-1:0]   PrevPC
`else
   output logic                Underflow
`endif
);

   typedef enum logic [2:0] {
      OP_NEXT   = 3'b000,
      OP_BRANCH = 3'b001,
      OP_JUMP   = 3'b010,
      OP_CALL   = 3'b011,
      OP_RETURN = 3'b100,
      OP_HOLD   = 3'b101
   } op_e;

   // A single-entry stack still needs a 1-bit pointer; it simply stays at 0.
   localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(STACK_DEPTH - 1);
   localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

   logic [ADDR_W-1:0]  pc_q, pc_nxt;
   logic [DEPTH_W-1:0] depth_q, depth_nxt;
   logic [PTR_W-1:0]   wp_q, wp_nxt, wp_inc, wp_dec;
   logic [ADDR_W-1:0]  ras_q [STACK_DEPTH];
   logic               ovf_q, unf_q;
   logic               ovf_set, unf_set;
   logic               push, pop;
   logic               empty, full;
   logic [ADDR_W-1:0]  pc_inc;
   logic [ADDR_W-1:0]  offset_ext;

   assign empty      = (depth_q == '0);
   assign full       = (depth_q == DEPTH_MAX);
   assign pc_inc     = pc_q + ADDR_W'(1);
   // Size cast of a signed operand sign-extends the displacement to PC width.
   assign offset_ext = ADDR_W'($signed(Offset));
   assign wp_inc     = (wp_q == PTR_LAST) ? '0 : wp_q + PTR_W'(1);
   assign wp_dec     = (wp_q == '0) ? PTR_LAST : wp_q - PTR_W'(1);

   // Decode the operation into next PC, stack push/pop and error-set strobes.
   always_comb begin
      pc_nxt  = pc_q;
      push    = 1'b0;
      pop     = 1'b0;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      if (!Stall) begin
         case (op_e'(Op))
            OP_NEXT:   pc_nxt = pc_inc;
            OP_BRANCH: pc_nxt = pc_q + offset_ext;
            OP_JUMP:   pc_nxt = Target;
            OP_CALL: begin
               push    = 1'b1;
               pc_nxt  = Target;
               ovf_set = full;
            end
            OP_RETURN: begin
               if (empty) begin
                  pc_nxt  = pc_inc;
                  unf_set = 1'b1;
               end else begin
                  pop    = 1'b1;
                  pc_nxt = ras_q[wp_dec];
               end
            end
            default:   pc_nxt = pc_q;
         endcase
      end
   end

   // Depth saturates on push while full: the oldest entry is silently overwritten.
   always_comb begin
      depth_nxt = depth_q;
      wp_nxt    = wp_q;
      if (push) begin
         wp_nxt = wp_inc;
         if (!full) depth_nxt = depth_q + DEPTH_W'(1);
      end else if (pop) begin
         wp_nxt    = wp_dec;
         depth_nxt = depth_q - DEPTH_W'(1);
      end
   end

   // PC, stack bookkeeping and sticky flags; a new error on the clearing edge wins.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         pc_q    <= RESET_VECTOR;
         depth_q <= '0;
         wp_q    <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         pc_q    <= pc_nxt;
         depth_q <= depth_nxt;
         wp_q    <= wp_nxt;
         ovf_q   <= ovf_set | (ovf_q & ~ClearErr);
         unf_q   <= unf_set | (unf_q & ~ClearErr);
      end
   end

   // Stack storage needs no reset: entries are only read once Depth says they are valid.
   always_ff @(posedge Clock) begin
      if (push) ras_q[wp_q] <= pc_inc;
   end

`ifdef PC_SEQ_PREV_EN
   logic [ADDR_W-1:0] prev_pc_q;

   // Capture the outgoing PC on every non-stalled edge for fault-address reporting.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)       prev_pc_q <= RESET_VECTOR;
      else if (!Stall) prev_pc_q <= pc_q;
   end

   assign PrevPC = prev_pc_q;
`else
`endif

   assign PC        = pc_q;
   assign Depth     = depth_q;
   assign Empty     = empty;
   assign Full      = full;
   assign Overflow  = ovf_q;
   assign Underflow = unf_q;

endmodule
